// File: rtl/floo_route_decode.sv
// rtl/floo_route_decode.sv - per-hop source-route decoder with wormhole lock and 2-entry output buffer
module floo_route_decode #(
    parameter int NumPorts   = 5,
    parameter int RouteWidth = 32,
    parameter int DataWidth  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [RouteWidth-1:0] route_i,
    input  logic [DataWidth-1:0]  data_i,
    input  logic                  last_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [NumPorts-1:0]   port_o,
    output logic [RouteWidth-1:0] route_o,
    output logic [DataWidth-1:0]  data_o,
    output logic                  last_o,
    output logic                  err_o
);

    localparam int PortIdxWidth = $clog2(NumPorts);

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [NumPorts-1:0]   port;
        logic [RouteWidth-1:0] route;
        logic [DataWidth-1:0]  data;
        logic                  last;
    } entry_t;

    state_e                  state_q, state_d;
    logic [PortIdxWidth-1:0] lock_q, lock_d;
    entry_t                  mem_q [2];
    entry_t                  push_entry;
    entry_t                  head_entry;
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              count_q;
    logic                    err_q, err_d;
    logic                    accept, push, pop;
    logic [PortIdxWidth-1:0] idx;
    logic                    idx_ok;

    // Lowest route field selects this hop's output port.
    assign idx    = route_i[PortIdxWidth-1:0];
    assign idx_ok = (int'(idx) < NumPorts);

    // Backpressure only from registered occupancy; a dropped packet is always drained.
    assign ready_o = !rst_i && ((state_q == DROP) || (count_q < 2'd2));
    assign accept  = valid_i && ready_o;
    assign valid_o = (count_q != 2'd0);
    assign pop     = valid_o && ready_i;

    assign head_entry = mem_q[rd_ptr_q];
    assign port_o     = head_entry.port;
    assign route_o    = head_entry.route;
    assign data_o     = head_entry.data;
    assign last_o     = head_entry.last;
    assign err_o      = err_q;

    // Packet-level FSM: decode heads, lock the port for bodies, swallow bad packets.
    always_comb begin
        state_d          = state_q;
        lock_d           = lock_q;
        push             = 1'b0;
        err_d            = 1'b0;
        push_entry.port  = '0;
        push_entry.route = route_i;
        push_entry.data  = data_i;
        push_entry.last  = last_i;
        case (state_q)
            HEAD: begin
                if (accept) begin
                    if (idx_ok) begin
                        push             = 1'b1;
                        push_entry.port  = NumPorts'(1) << idx;
                        push_entry.route = route_i >> PortIdxWidth;
                        lock_d           = idx;
                        if (!last_i) state_d = BODY;
                    end else begin
                        err_d = 1'b1;
                        if (!last_i) state_d = DROP;
                    end
                end
            end
            BODY: begin
                if (accept) begin
                    push            = 1'b1;
                    push_entry.port = NumPorts'(1) << lock_q;
                    if (last_i) state_d = HEAD;
                end
            end
            DROP: begin
                if (accept && last_i) state_d = HEAD;
            end
            default: state_d = HEAD;
        endcase
    end

    // State, lock, error pulse and FIFO storage/pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= HEAD;
            lock_q   <= '0;
            err_q    <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_floo_route_decode.sv
// tb/tb_floo_route_decode.sv - scoreboard bench for floo_route_decode
module tb_floo_route_decode;

    localparam int NP = 5;
    localparam int RW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [RW-1:0] route_i;
    logic [DW-1:0] data_i;
    logic          last_i;
    logic          valid_o;
    logic          ready_i;
    logic [NP-1:0] port_o;
    logic [RW-1:0] route_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          err_o;

    floo_route_decode #(.NumPorts(NP), .RouteWidth(RW), .DataWidth(DW)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .route_i (route_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .port_o  (port_o),
        .route_o (route_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] port;
        logic [RW-1:0] route;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_wait;
    int   last_acc_cyc;
    logic err_exp = 1'b0;
    int   m_state = 0;
    int   m_lock = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference behaviour for one accepted flit.
    task automatic model_accept(input logic [RW-1:0] r, input logic [DW-1:0] d, input logic l);
        exp_t e;
        int   idx;
        idx = int'(r[2:0]);
        case (m_state)
            0: begin
                if (idx < NP) begin
                    e.port = NP'(1) << idx; e.route = r >> 3; e.data = d; e.last = l;
                    q.push_back(e);
                    m_lock = idx;
                    if (!l) m_state = 1;
                end else begin
                    err_exp = 1'b1;
                    if (!l) m_state = 2;
                end
            end
            1: begin
                e.port = NP'(1) << m_lock; e.route = r; e.data = d; e.last = l;
                q.push_back(e);
                if (l) m_state = 0;
            end
            default: if (l) m_state = 0;
        endcase
    endtask

    // Present a flit from posedge+1 and hold it until accepted; valid_i stays high on return.
    task automatic send(input logic [RW-1:0] r, input logic [DW-1:0] d, input logic l);
        int t;
        valid_i = 1'b1; route_i = r; data_i = d; last_i = l;
        t = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            t++;
            if (t > 100) break;
        end
        if (t > 100) begin
            chk("accept_timeout", 32'(t), 32'd0);
        end else begin
            @(posedge clk);
            last_acc_cyc = cyc;
            model_accept(r, d, l);
            #1;
        end
        last_wait = t;
    endtask

    task automatic idle();
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Output monitor: compare every popped flit and the error pulse against the model.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i) begin
            chk("err_o", 32'(err_o), 32'(err_exp));
            err_exp = 1'b0;
            if (valid_o && ready_i) begin
                pop_cyc.push_back(cyc);
                n_checks++;
                assert (q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL spurious_output: observed port %h route %h, expected no flit", port_o, route_o);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("out_port", 32'(port_o), 32'(e.port));
                    chk("out_route", 32'(route_o), 32'(e.route));
                    chk("out_data", 32'(data_o), 32'(e.data));
                    chk("out_last", 32'(last_o), 32'(e.last));
                end
            end
        end
    end

    initial begin
        int acc0;
        rst_i = 1'b1; valid_i = 1'b0; route_i = '0; data_i = '0; last_i = 1'b0; ready_i = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready_o), 32'd1);
        chk("post_rst_valid", 32'(valid_o), 32'd0);
        chk("post_rst_port", 32'(port_o), 32'd0);
        chk("post_rst_route", 32'(route_o), 32'd0);
        chk("post_rst_data", 32'(data_o), 32'd0);
        chk("post_rst_last", 32'(last_o), 32'd0);
        @(posedge clk); #1;

        // Single flit, one-cycle latency
        send(12'h0A3, 16'h1234, 1'b1);
        idle();
        @(negedge clk);
        chk("lat_valid", 32'(valid_o), 32'd1);
        chk("single_port", 32'(port_o), 32'b01000);
        chk("single_route", 32'(route_o), 32'h014);
        drain();

        // Three-flit packet locked to port 1
        @(posedge clk); #1;
        send(12'h0A9, 16'hA001, 1'b0);
        send(12'hFFF, 16'hA002, 1'b0);
        send(12'hFFF, 16'hA003, 1'b1);
        idle();
        drain();

        // Back-pressure: two accepted, third waits
        @(posedge clk); #1 ready_i = 1'b0;
        send(12'h0A1, 16'hB001, 1'b1);
        send(12'h0A2, 16'hB002, 1'b1);
        fork
            send(12'h0A4, 16'hB003, 1'b1);
            begin
                @(negedge clk);
                chk("stall_ready_0", 32'(ready_o), 32'd0);
                repeat (2) @(negedge clk);
                chk("stall_ready_1", 32'(ready_o), 32'd0);
                chk("stall_valid", 32'(valid_o), 32'd1);
                @(posedge clk); #1 ready_i = 1'b1;
            end
        join
        idle();
        drain();

        // Invalid head: error pulse, whole packet dropped, then a valid one
        @(posedge clk); #1;
        send(12'h006, 16'hC001, 1'b0);
        chk("drop_head_wait", 32'(last_wait), 32'd0);
        send(12'h123, 16'hC002, 1'b1);
        chk("drop_body_wait", 32'(last_wait), 32'd0);
        send(12'h00C, 16'hC003, 1'b1);
        idle();
        drain();

        // Reset in the middle of a packet
        @(posedge clk); #1 ready_i = 1'b0;
        send(12'h002, 16'hD001, 1'b0);
        route_i = 12'h555; data_i = 16'hD002; last_i = 1'b0;
        rst_i = 1'b1;
        q.delete(); m_state = 0; m_lock = 0; err_exp = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(ready_o), 32'd0);
        @(posedge clk); #1 rst_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_ready_up", 32'(ready_o), 32'd1);
        @(posedge clk); #1 ready_i = 1'b1;
        send(12'h004, 16'hD003, 1'b1);
        idle();
        @(negedge clk);
        chk("midrst_head_port", 32'(port_o), 32'b10000);
        chk("midrst_head_route", 32'(route_o), 32'h000);
        drain();

        // Sustained throughput, 8 single-flit packets
        @(posedge clk); #1;
        pop_cyc.delete();
        acc0 = 0;
        for (int i = 0; i < 8; i++) begin
            send(RW'((i * 8) + (i % NP)), DW'($urandom), 1'b1);
            if (i == 0) acc0 = last_acc_cyc;
            chk("stream_ready", 32'(last_wait), 32'd0);
        end
        idle();
        drain();
        chk("stream_count", 32'(pop_cyc.size()), 32'd8);
        if (pop_cyc.size() == 8) begin
            chk("stream_first", 32'(pop_cyc[0]), 32'(acc0 + 1));
            chk("stream_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/floo_route_decode.md
# floo_route_decode

Per-hop source-route consumer for FlooNoC routers and endpoints running `SourceRouting`. On each packet head flit it pops the lowest port-index field off the pre-computed route, converts it to a one-hot output-port select, and shifts the remaining route down for the next hop. Body flits are wormhole-locked to the head's port. Output is registered through a 2-entry elastic buffer with valid/ready handshakes. Heads carrying an out-of-range port index are dropped with an error pulse.

## Interface
- `NumPorts`, 5: number of router output ports; must be ≥2.
- `RouteWidth`, 32: width of the route field.
- `DataWidth`, 64: width of the opaque flit payload.
- `PortIdxWidth` (localparam): `$clog2(NumPorts)`.
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `valid_i` in 1: input flit valid.
- `ready_o` out 1: input flit accepted when `valid_i && ready_o`.
- `route_i` in RouteWidth: route field of the input flit.
- `data_i` in DataWidth: payload.
- `last_i` in 1: flit is the last of its packet. A single-flit packet has head and last in the same flit.
- `valid_o` out 1: output flit valid.
- `ready_i` in 1: downstream ready.
- `port_o` out NumPorts: one-hot output-port select.
- `route_o` out RouteWidth: route after this hop.
- `data_o` out DataWidth: payload.
- `last_o` out 1: last flag.
- `err_o` out 1: one-cycle pulse when an invalid head is accepted.

## Operation
- FSM states:
  - `HEAD`: next accepted flit is a head.
  - `BODY`: inside a valid packet.
  - `DROP`: inside an invalid packet.
- Head decode in `HEAD`: `idx = route_i[PortIdxWidth-1:0]`.
  - If `idx < NumPorts`:
    - push a flit with `port_o = 1 << idx` and `route_o = route_i >> PortIdxWidth` (zero-filled at the MSBs).
    - Latch `idx` as the locked port.
    - If `!last_i`, go to `BODY`.
  - If `idx >= NumPorts`:
    - assert `err_o` on the next cycle and push nothing.
    - If `!last_i`, go to `DROP`.
- `BODY`: every accepted flit is pushed with the locked `port_o`; `route_i` passes through unchanged. When `last_i` is accepted, go to `HEAD`.
- `DROP`: every accepted flit is discarded. `ready_o=1` regardless of buffer occupancy. When `last_i` is accepted, go to `HEAD`. No further `err_o`.
- Buffer: 2-entry FIFO of {port, route, data, last}, strictly in order.
  - `ready_o = (count < 2)` in `HEAD`/`BODY`; `ready_o = 1` in `DROP`.
  - `ready_o` depends only on registered state, never combinationally on `valid_i` or `ready_i`.
  - `valid_o = (count > 0)`; outputs show the head entry.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, including at count==1.
  - No push occurs at count==2.
- Outputs are stable while `valid_o && !ready_i`.

## Timing
- Reset, applied while `rst_i=1` and on the first cycle after:
  - `valid_o=0`, `err_o=0`, `port_o='0`, `route_o='0`, `data_o='0`, `last_o=0`.
  - FIFO empty, state `HEAD`.
  - `ready_o=0` while `rst_i=1`; `ready_o=1` on the first cycle after deassertion.
- Latency: flit accepted in cycle N → `valid_o` in cycle N+1 when the FIFO was empty.
- Throughput: 1 flit/cycle sustained with `ready_i=1`.
- `err_o`: high exactly in cycle N+1 for an invalid head accepted in cycle N.
- Reset mid-packet: FIFO contents are discarded and the locked port is cleared. The next accepted flit is decoded as a head.
- A route exhausted to zero is legal: `idx=0` selects port 0.

## Test plan
- `NumPorts=5`, `RouteWidth=12`, single flit `route_i=12'h0A3`, `last_i=1` → next cycle `valid_o=1`, `port_o=5'b01000`, `route_o=12'h014`, `last_o=1`.
- 3-flit packet: head route low bits 3'd1, body `route_i=12'hFFF` → three outputs, all `port_o=5'b00010`; head `route_o` shifted, bodies `route_o=12'hFFF`; state `HEAD` after the last flit.
- `ready_i=0`, three back-to-back single-flit packets → two accepted, `ready_o=0` from the cycle after the second. Raise `ready_i` → pops in order, one per cycle, third accepted once `count<2`.
- 2-flit packet with head idx 3'd6 → `err_o=1` for one cycle after the head, both flits consumed with `ready_o=1`, `valid_o` stays 0. Following packet (idx 3'd4) → `port_o=5'b10000`.
- Reset mid-packet: head (idx 2) accepted, one body pending, `rst_i=1` one cycle → `valid_o=0`, FIFO empty. Next flit with `route_i=12'h004` is decoded as a head → `port_o=5'b10000`, `route_o=12'h000`.
- Continuous `valid_i=1`, `ready_i=1`, 8 single-flit packets → 8 outputs on consecutive cycles, first one cycle after first acceptance, `ready_o` never drops.
